// File: rtl/bsort100_pkg.sv
// Shared types and constants for the bsort100 accelerator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bsort100_pkg;

  localparam int N_ELEM = 100;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 7;
  localparam int N_CH   = 2;
  localparam int IDX_W  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OUTER,
    S_RD,
    S_CMP,
    S_CHECK,
    S_DONE
  } state_t;

  // Power-up contents: strictly descending, the bubble-sort worst case.
  function automatic logic [WORD_W-1:0] reset_word(input int k);
    return WORD_W'(N_ELEM - 1 - k);
  endfunction

endpackage

// File: rtl/bsort100_mem.sv
// 100x32 flop array: one registered read pair and one write pair for the sorter, two slave channels for the host.
// Latency: sorter reads and slave responses appear one cycle after the request; writes land at the clock edge.
// Backpressure: none; slave channels are only serviced while idle=1, otherwise requests are dropped with no DataRdy.
module bsort100_mem
  import bsort100_pkg::*;
#(
  parameter int BASE = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     idle,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         rd_idx_a,
  input  logic [IDX_W-1:0]         rd_idx_b,
  output logic [WORD_W-1:0]        rd_dat_a,
  output logic [WORD_W-1:0]        rd_dat_b,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx_a,
  input  logic [IDX_W-1:0]         wr_idx_b,
  input  logic [WORD_W-1:0]        wr_dat_a,
  input  logic [WORD_W-1:0]        wr_dat_b,
  input  logic [N_CH-1:0]          s_oe,
  input  logic [N_CH-1:0]          s_we,
  input  logic [N_CH*ADDR_W-1:0]   s_addr,
  input  logic [N_CH*DATA_W-1:0]   s_wdat,
  input  logic [N_CH*SIZE_W-1:0]   s_size,
  output logic [N_CH*DATA_W-1:0]   s_rdat,
  output logic [N_CH-1:0]          s_rdy
);

  logic [WORD_W-1:0] mem     [N_ELEM];
  logic [WORD_W-1:0] s_rword [N_CH];
  logic [IDX_W-1:0]  s_idx   [N_CH];
  logic [WORD_W-1:0] s_wword [N_CH];
  logic [N_CH-1:0]   hit;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic              unused_wdat_hi;
    assign addr     = s_addr[c*ADDR_W +: ADDR_W];
    assign size     = s_size[c*SIZE_W +: SIZE_W];
    // Only full, aligned 32-bit accesses inside the array window are hits.
    assign hit[c]   = (size == SIZE_W'(WORD_W)) && (addr[1:0] == 2'b00) &&
                      (addr >= ADDR_W'(BASE)) &&
                      (addr <= ADDR_W'(BASE + 4 * (N_ELEM - 1)));
    assign s_idx[c] = IDX_W'((addr - ADDR_W'(BASE)) >> 2);
    assign s_wword[c] = s_wdat[c*DATA_W +: WORD_W];
    // Upper half of each write lane carries no information for a 32-bit array.
    assign unused_wdat_hi = ^s_wdat[c*DATA_W+WORD_W +: DATA_W-WORD_W];
  end

  // Array update: reset reload, host writes while idle (channel 1 last so it wins), sorter swaps otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_ELEM; k++) mem[k] <= reset_word(k);
    end else if (idle) begin
      for (int c = 0; c < N_CH; c++) begin
        if (s_we[c] && hit[c]) mem[s_idx[c]] <= s_wword[c];
      end
    end else if (wr_en) begin
      mem[wr_idx_a] <= wr_dat_a;
      mem[wr_idx_b] <= wr_dat_b;
    end
  end

  // Registered operand fetch for the compare stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_dat_a <= '0;
      rd_dat_b <= '0;
    end else if (rd_en) begin
      rd_dat_a <= mem[rd_idx_a];
      rd_dat_b <= mem[rd_idx_b];
    end
  end

  // Slave response: pulse on every idle request; data is the pre-write word on a hit, zero otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_rdy <= '0;
      for (int c = 0; c < N_CH; c++) s_rword[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        s_rdy[c]   <= idle && (s_oe[c] || s_we[c]);
        s_rword[c] <= (idle && s_oe[c] && hit[c]) ? mem[s_idx[c]] : '0;
      end
    end
  end

  // Zero-extend each channel's 32-bit word onto its 64-bit lane.
  always_comb begin
    s_rdat = '0;
    for (int c = 0; c < N_CH; c++) s_rdat[c*DATA_W +: WORD_W] = s_rword[c];
  end

endmodule

// File: rtl/bsort100_main.sv
// bsort100 kernel: in-place ascending signed bubble sort of a 100-word array; BSORT_EARLY_EXIT_EN stops after a swap-free pass.
// Latency: 2*passes + 2*inner_iterations + 1 cycles from start to done (201 best case with early exit, 10099 worst).
// Backpressure: start is honoured only in IDLE; slave accesses are ignored (no DataRdy) while sorting.
module bsort100_main
  import bsort100_pkg::*;
#(
  parameter int MEM_var_26078_26084 = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_port,
  input  logic [1:0]             S_oe_ram,
  input  logic [1:0]             S_we_ram,
  input  logic [19:0]            S_addr_ram,
  input  logic [127:0]           S_Wdata_ram,
  input  logic [13:0]            S_data_ram_size,
  output logic                   done_port,
  output logic [127:0]           Sout_Rdata_ram,
  output logic [1:0]             Sout_DataRdy
);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  i_cnt, j_cnt, j_nxt;
  logic [WORD_W-1:0] op_a, op_b;
  logic              idle, rd_en, swap_en, gt, last_j, finish;

  assign j_nxt  = j_cnt + IDX_W'(1);
  assign gt     = $signed(op_a) > $signed(op_b);
  assign last_j = (j_cnt == (IDX_W'(N_ELEM - 2) - i_cnt));

`ifdef BSORT_EARLY_EXIT_EN
  logic sorted;
  assign finish = sorted || (i_cnt == IDX_W'(N_ELEM - 2));
`else
  assign finish = (i_cnt == IDX_W'(N_ELEM - 2));
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one pass is OUTER, (RD,CMP) per pair, then CHECK.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_port) state_nxt = S_OUTER;
      S_OUTER: state_nxt = S_RD;
      S_RD:    state_nxt = S_CMP;
      S_CMP:   state_nxt = last_j ? S_CHECK : S_RD;
      S_CHECK: state_nxt = finish ? S_DONE : S_OUTER;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: slave mux, operand fetch, swap strobe, done pulse.
  always_comb begin
    idle      = (state == S_IDLE);
    rd_en     = (state == S_RD);
    swap_en   = (state == S_CMP) && gt;
    done_port = (state == S_DONE);
  end

  // Loop counters and the per-pass "no swaps seen" flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      i_cnt <= '0;
      j_cnt <= '0;
`ifdef BSORT_EARLY_EXIT_EN
      sorted <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE:  if (start_port) i_cnt <= '0;
        S_OUTER: begin
          j_cnt <= '0;
`ifdef BSORT_EARLY_EXIT_EN
          sorted <= 1'b1;
`endif
        end
        S_CMP: begin
          if (!last_j) j_cnt <= j_nxt;
`ifdef BSORT_EARLY_EXIT_EN
          if (gt) sorted <= 1'b0;
`endif
        end
        S_CHECK: if (!finish) i_cnt <= i_cnt + IDX_W'(1);
        default: ;
      endcase
    end
  end

  bsort100_mem #(
    .BASE (MEM_var_26078_26084)
  ) u_mem (
    .clock    (clock),
    .reset    (reset),
    .idle     (idle),
    .rd_en    (rd_en),
    .rd_idx_a (j_cnt),
    .rd_idx_b (j_nxt),
    .rd_dat_a (op_a),
    .rd_dat_b (op_b),
    .wr_en    (swap_en),
    .wr_idx_a (j_cnt),
    .wr_idx_b (j_nxt),
    .wr_dat_a (op_b),
    .wr_dat_b (op_a),
    .s_oe     (S_oe_ram),
    .s_we     (S_we_ram),
    .s_addr   (S_addr_ram),
    .s_wdat   (S_Wdata_ram),
    .s_size   (S_data_ram_size),
    .s_rdat   (Sout_Rdata_ram),
    .s_rdy    (Sout_DataRdy)
  );

endmodule

// File: tb/tb_bsort100_main.sv
// Self-checking bench for bsort100_main: slave-port vectors, sort latency/content against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bsort100_main;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start_port = 1'b0;
  logic [1:0]   S_oe_ram = '0;
  logic [1:0]   S_we_ram = '0;
  logic [19:0]  S_addr_ram = '0;
  logic [127:0] S_Wdata_ram = '0;
  logic [13:0]  S_data_ram_size = '0;
  logic         done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  int n_pass = 0;
  int n_total = 0;
  int ref_mem [100];

  always #5 clock = ~clock;

  bsort100_main #(.MEM_var_26078_26084(256)) dut (
    .clock           (clock),
    .reset           (reset),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  typedef struct {
    int          ch;
    logic [9:0]  addr;
    logic [6:0]  size;
    logic [63:0] exp_dat;
  } rvec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 100; k++) ref_mem[k] = 99 - k;
  endtask

  // One slave access on one channel: drive at a falling edge, sample one cycle later.
  task automatic slave_op(input int ch, input bit oe, input bit we, input logic [9:0] addr,
                          input logic [6:0] size, input logic [31:0] wdat,
                          output logic [63:0] rdat, output logic rdy);
    @(negedge clock);
    S_oe_ram[ch] = oe;
    S_we_ram[ch] = we;
    S_addr_ram[ch*10 +: 10] = addr;
    S_data_ram_size[ch*7 +: 7] = size;
    S_Wdata_ram[ch*64 +: 64] = {32'hA5A5_A5A5, wdat};
    @(negedge clock);
    rdat = Sout_Rdata_ram[ch*64 +: 64];
    rdy  = Sout_DataRdy[ch];
    S_oe_ram[ch] = 1'b0;
    S_we_ram[ch] = 1'b0;
  endtask

  task automatic load_model();
    logic [63:0] d;
    logic r;
    for (int k = 0; k < 100; k++)
      slave_op(k % 2, 1'b0, 1'b1, 10'(256 + 4 * k), 7'd32, 32'(ref_mem[k]), d, r);
  endtask

  task automatic readback(input string tag);
    logic [63:0] d;
    logic r;
    for (int k = 0; k < 100; k++) begin
      slave_op(k % 2, 1'b1, 1'b0, 10'(256 + 4 * k), 7'd32, 32'h0, d, r);
      if (k == 0) check({tag, "_rdy"}, {63'h0, r}, 64'h1);
      check($sformatf("%s[%0d]", tag, k), d, {32'h0, 32'(ref_mem[k])});
    end
  endtask

  // Reference: plain bubble sort over ref_mem, counting passes and inner iterations.
  task automatic model_sort(output int passes, output int iters);
    int t;
    bit swapped;
    passes = 0;
    iters = 0;
    for (int p = 0; p < 99; p++) begin
      swapped = 1'b0;
      passes++;
      for (int q = 0; q < 99 - p; q++) begin
        iters++;
        if (ref_mem[q] > ref_mem[q+1]) begin
          t = ref_mem[q];
          ref_mem[q] = ref_mem[q+1];
          ref_mem[q+1] = t;
          swapped = 1'b1;
        end
      end
`ifdef BSORT_EARLY_EXIT_EN
      if (!swapped) break;
`endif
    end
  endtask

  task automatic run_sort(input string tag, input bit hold, input bit poke);
    int cnt, lat, pulses, p, it;
    bit seen;
    model_sort(p, it);
    cnt = 0; lat = -1; pulses = 0; seen = 1'b0;
    @(negedge clock);
    start_port = 1'b1;
    while (!seen && cnt < 12000) begin
      @(negedge clock);
      cnt++;
      if (!hold) start_port = 1'b0;
      if (poke && cnt == 21) begin
        check({tag, "_busy_rdy"}, {62'h0, Sout_DataRdy}, 64'h0);
        S_oe_ram = 2'b00;
        S_we_ram = 2'b00;
      end
      if (poke && cnt == 20) begin
        S_oe_ram = 2'b11;
        S_we_ram = 2'b11;
        S_addr_ram = {10'd256, 10'd256};
        S_data_ram_size = {7'd32, 7'd32};
        S_Wdata_ram = {64'h7FFF_FFFF, 64'h8000_0000};
      end
      if (done_port) begin
        seen = 1'b1;
        lat = cnt;
        pulses++;
      end
    end
    start_port = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (done_port) pulses++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(2 * p + 2 * it + 1));
    check({tag, "_done_pulses"}, 64'(pulses), 64'd1);
  endtask

  initial begin
    rvec_t tbl [10];
    logic [63:0] d;
    logic r;
    int pulses;

    tbl[0] = '{0, 10'd256, 7'd32, 64'd99};
    tbl[1] = '{1, 10'd260, 7'd32, 64'd98};
    tbl[2] = '{0, 10'd648, 7'd32, 64'd1};
    tbl[3] = '{1, 10'd400, 7'd32, 64'd63};
    tbl[4] = '{0, 10'd652, 7'd32, 64'd0};
    tbl[5] = '{1, 10'd257, 7'd32, 64'd0};
    tbl[6] = '{0, 10'd256, 7'd16, 64'd0};
    tbl[7] = '{1, 10'd656, 7'd32, 64'd0};
    tbl[8] = '{0, 10'd252, 7'd32, 64'd0};
    tbl[9] = '{1, 10'd300, 7'd64, 64'd0};

    do_reset();
    check("rst_done", {63'h0, done_port}, 64'h0);
    check("rst_rdy", {62'h0, Sout_DataRdy}, 64'h0);
    check("rst_rdata_lo", Sout_Rdata_ram[63:0], 64'h0);
    check("rst_rdata_hi", Sout_Rdata_ram[127:64], 64'h0);

    for (int v = 0; v < 10; v++) begin
      slave_op(tbl[v].ch, 1'b1, 1'b0, tbl[v].addr, tbl[v].size, 32'h0, d, r);
      check($sformatf("tbl%0d_rdy", v), {63'h0, r}, 64'h1);
      check($sformatf("tbl%0d_dat", v), d, tbl[v].exp_dat);
    end

    // oe+we on one channel: old value returned, new value stored.
    slave_op(0, 1'b1, 1'b1, 10'd256, 7'd32, 32'd1234, d, r);
    check("rmw_old", d, 64'd99);
    slave_op(1, 1'b1, 1'b0, 10'd256, 7'd32, 32'h0, d, r);
    check("rmw_new", d, 64'd1234);

    // Both channels write word 10 together: channel 1 wins.
    @(negedge clock);
    S_we_ram = 2'b11;
    S_addr_ram = {10'd296, 10'd296};
    S_data_ram_size = {7'd32, 7'd32};
    S_Wdata_ram = {64'd222, 64'd111};
    @(negedge clock);
    check("dual_rdy", {62'h0, Sout_DataRdy}, 64'h3);
    S_we_ram = 2'b00;
    slave_op(0, 1'b1, 1'b0, 10'd296, 7'd32, 32'h0, d, r);
    check("dual_ch1_wins", d, 64'd222);

    // Fresh reset, miss writes must not land, then sort the descending pattern.
    do_reset();
    slave_op(0, 1'b0, 1'b1, 10'd257, 7'd32, 32'hDEAD_BEEF, d, r);
    check("miss_wr_rdy", {63'h0, r}, 64'h1);
    slave_op(1, 1'b0, 1'b1, 10'd256, 7'd16, 32'hDEAD_BEEF, d, r);
    slave_op(0, 1'b0, 1'b1, 10'd656, 7'd32, 32'hDEAD_BEEF, d, r);
    slave_op(1, 1'b1, 1'b0, 10'd256, 7'd32, 32'h0, d, r);
    check("miss_wr_unchanged", d, 64'd99);
    run_sort("desc", 1'b0, 1'b0);
    readback("desc");

    // Already ascending.
    for (int k = 0; k < 100; k++) ref_mem[k] = k;
    load_model();
    run_sort("asc", 1'b0, 1'b0);
    readback("asc");

    // Signed ordering, start held high, and a host write attempted while busy.
    for (int k = 0; k < 100; k++) ref_mem[k] = 100;
    ref_mem[0] = 5; ref_mem[1] = -3; ref_mem[2] = 7; ref_mem[3] = -3; ref_mem[4] = 0;
    load_model();
    run_sort("signed", 1'b1, 1'b1);
    readback("signed");

    // Random signed data with many duplicates and some full-range extremes.
    for (int k = 0; k < 100; k++)
      ref_mem[k] = (k % 7 == 0) ? int'($urandom) : int'($urandom_range(0, 30)) - 15;
    load_model();
    run_sort("rand", 1'b0, 1'b0);
    readback("rand");

    // Reset in the middle of a sort: no done, back to IDLE, reset pattern restored.
    do_reset();
    pulses = 0;
    @(negedge clock);
    start_port = 1'b1;
    @(negedge clock);
    start_port = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (done_port) pulses++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done_port) pulses++;
    end
    check("midreset_no_done", 64'(pulses), 64'd0);
    for (int k = 0; k < 100; k++) ref_mem[k] = 99 - k;
    readback("midreset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
